// File: rtl/ucsbece154b_mem_arbiter.sv
// ucsbece154b_mem_arbiter: shares one main-memory port between icache line refills and data accesses.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the D-side wins simultaneous requests.
module ucsbece154b_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           IReq_i,
  input  logic [ADDR_W-1:0]              IAddr_i,
  output logic                           IWordValid_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] IWordIdx_o,
  output logic [31:0]                    IData_o,
  output logic                           IDone_o,
  input  logic                           DReq_i,
  input  logic                           DWe_i,
  input  logic [ADDR_W-1:0]              DAddr_i,
  input  logic [31:0]                    DWData_i,
  output logic [31:0]                    DRData_o,
  output logic                           DDone_o,
  output logic                           MemReq_o,
  output logic                           MemWe_o,
  output logic                           MemBurst_o,
  output logic [ADDR_W-1:0]              MemAddr_o,
  output logic [31:0]                    MemWData_o,
  input  logic                           MemAck_i,
  input  logic                           MemRValid_i,
  input  logic [31:0]                    MemRData_i
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = IDX_W + 2;
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, I_CMD, I_DATA, D_CMD, D_RDATA} state_t;

  state_t            state;
  logic [IDX_W-1:0]  beatCnt;
  logic              grantD;
  logic              lastBeat;
  logic              iBeat;
  logic              dReadBeat;
  logic [ADDR_W-1:0] lineBase;

`ifdef MEM_ARB_RR_EN
  logic lastGrantD;
  // Contested grants alternate; an uncontested request is always served.
  assign grantD = DReq_i & (~IReq_i | ~lastGrantD);
`else
  assign grantD = DReq_i;
`endif

  assign lineBase = IAddr_i & LINE_MASK;
  assign lastBeat = (beatCnt == LAST_IDX);

  // NOTE: return-path outputs are continuous assigns with an explicit else value,
  // so they stay zero-latency without any chance of holding state.
  assign iBeat        = (state == I_DATA) & MemRValid_i;
  assign dReadBeat    = (state == D_RDATA) & MemRValid_i;
  assign IWordValid_o = iBeat;
  assign IWordIdx_o   = beatCnt;
  assign IData_o      = iBeat ? MemRData_i : 32'h0;
  assign IDone_o      = iBeat & lastBeat;
  assign DDone_o      = ((state == D_CMD) & MemAck_i & MemWe_o) | dReadBeat;
  assign DRData_o     = dReadBeat ? MemRData_i : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beatCnt    <= '0;
      MemReq_o   <= 1'b0;
      MemWe_o    <= 1'b0;
      MemBurst_o <= 1'b0;
      MemAddr_o  <= '0;
      MemWData_o <= 32'h0;
`ifdef MEM_ARB_RR_EN
      lastGrantD <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments only, so every branch sees pre-edge values.
      unique case (state)
        IDLE: begin
          if (grantD) begin
            state      <= D_CMD;
            MemReq_o   <= 1'b1;
            MemWe_o    <= DWe_i;
            MemBurst_o <= 1'b0;
            MemAddr_o  <= DAddr_i;
            MemWData_o <= DWData_i;
`ifdef MEM_ARB_RR_EN
            lastGrantD <= 1'b1;
`endif
          end else if (IReq_i) begin
            state      <= I_CMD;
            MemReq_o   <= 1'b1;
            MemWe_o    <= 1'b0;
            MemBurst_o <= 1'b1;
            MemAddr_o  <= lineBase;
            MemWData_o <= 32'h0;
`ifdef MEM_ARB_RR_EN
            lastGrantD <= 1'b0;
`endif
          end
        end
        I_CMD: begin
          if (MemAck_i) begin
            state      <= I_DATA;
            beatCnt    <= '0;
            MemReq_o   <= 1'b0;
            MemBurst_o <= 1'b0;
            MemAddr_o  <= '0;
          end
        end
        I_DATA: begin
          if (MemRValid_i) begin
            beatCnt <= beatCnt + 1'b1;
            if (lastBeat) state <= IDLE;
          end
        end
        D_CMD: begin
          if (MemAck_i) begin
            state      <= MemWe_o ? IDLE : D_RDATA;
            MemReq_o   <= 1'b0;
            MemWe_o    <= 1'b0;
            MemAddr_o  <= '0;
            MemWData_o <= 32'h0;
          end
        end
        D_RDATA: begin
          if (MemRValid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ucsbece154b_mem_arbiter.md
# ucsbece154b_mem_arbiter

Shares the single main-memory port between the instruction-cache refill path and the data-memory path of the pipelined RISC-V core. It accepts one outstanding request per side, sequences either a BLOCK_WORDS-beat line refill (I-side) or a single-word read/write (D-side), and steers returned data and completion pulses back to the requester. It sits between the icache miss handler and data port on one side and the memory model/controller on the other.

## Interface
Parameters:
- BLOCK_WORDS, 4, words per icache line; power of two, ≥2
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- IReq_i  in  1  icache refill request (level)
- IAddr_i  in  ADDR_W  miss address; line base = IAddr_i with low log2(BLOCK_WORDS)+2 bits cleared
- IWordValid_o  out  1  refill beat valid
- IWordIdx_o  out  log2(BLOCK_WORDS)  beat index of IData_o
- IData_o  out  32  refill beat data
- IDone_o  out  1  one-cycle pulse on final refill beat
- DReq_i  in  1  data request (level)
- DWe_i  in  1  1 = write, 0 = read
- DAddr_i  in  ADDR_W  word address
- DWData_i  in  32  write data
- DRData_o  out  32  read data, valid while DDone_o=1
- DDone_o  out  1  one-cycle completion pulse
- MemReq_o  out  1  command valid, held until MemAck_i
- MemWe_o  out  1  command is write
- MemBurst_o  out  1  command is BLOCK_WORDS-beat read
- MemAddr_o  out  ADDR_W  command address
- MemWData_o  out  32  write data
- MemAck_i  in  1  command accepted this cycle
- MemRValid_i  in  1  read beat valid
- MemRData_i  in  32  read beat data

## Operation
- States: IDLE, I_CMD, I_DATA, D_CMD, D_RDATA.
- IDLE: if DReq_i (priority, see Configuration) → D_CMD; else if IReq_i → I_CMD. Address/data/We captured into registers on the grant edge; later changes on inputs ignored.
- I_CMD: MemReq_o=1, MemBurst_o=1, MemAddr_o=line base. MemAck_i → I_DATA, beat counter cleared.
- I_DATA: each MemRValid_i: IWordValid_o=1, IData_o=MemRData_i, IWordIdx_o=counter, counter+1. Beat with counter=BLOCK_WORDS-1: IDone_o=1, → IDLE.
- D_CMD: MemReq_o=1, MemWe_o=captured DWe_i. Write: MemAck_i → DDone_o=1 same cycle, → IDLE. Read: MemAck_i → D_RDATA.
- D_RDATA: MemRValid_i → DDone_o=1, DRData_o=MemRData_i, → IDLE.
- Requester deasserts its req on the edge where its done pulse is high; a req still high in the following IDLE cycle is a new request.
- Req deasserted after grant (e.g. fetch flush): transaction runs to completion; done still pulses.
- MemRValid_i outside I_DATA/D_RDATA and MemAck_i outside *_CMD ignored.
- Counter is log2(BLOCK_WORDS) bits; wraps to 0 after final beat.

## Timing
- Reset (async assert): state IDLE, counter 0, last-grant flag = I; all outputs 0.
- Grant: req sampled high in IDLE at edge N → MemReq_o high from cycle N+1 (registered).
- IWordValid_o, IDone_o, DDone_o, IData_o, DRData_o are combinational from MemRValid_i/MemAck_i and state; zero latency.
- Minimum D write: 2 cycles req→done (ack in first command cycle). Minimum refill: 2 + BLOCK_WORDS cycles with back-to-back beats.
- At least one IDLE cycle between transactions.
- Reset mid-transaction: immediate return to IDLE, outputs 0; in-flight memory beats after deassertion ignored.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on simultaneous IReq_i/DReq_i in IDLE, grant the side not granted last (flag updated on every grant). Single request granted regardless.
- Undefined: fixed priority, D-side always wins simultaneous requests; flag not implemented.

## Test plan
- IReq_i=1, IAddr_i=0x0000_1234, ack at cycle 1, 4 beats 0xA0..0xA3 → MemAddr_o=0x0000_1230, MemBurst_o=1, IWordIdx_o 0..3, IDone_o only with 0xA3.
- DReq_i=1, DWe_i=1, DAddr_i=0x100, DWData_i=0xDEADBEEF, ack delayed 3 cycles → MemReq_o held 4 cycles, DDone_o with ack, MemWe_o=1.
- D read 0x200, ack then MemRValid_i with 0x1234_5678 two cycles later → DDone_o one cycle, DRData_o=0x12345678.
- IReq_i and DReq_i high together twice in a row → fixed: D,D; with MEM_ARB_RR_EN: D then I.
- reset low during I_DATA after beat 1 → all outputs 0 immediately; later MemRValid_i produces no IWordValid_o; new IReq_i restarts with index 0.
- IReq_i dropped after grant → full 4-beat burst still completes with IDone_o.
